baud_tick_gen: RTL

BAUD_TICK_GEN -- requirements
Module: baud_tick_gen

---
 rtl/baud_pkg.sv | 14 +
 rtl/frac_divider.sv | 60 ++++++
 rtl/baud_tick_gen.sv | 104 ++++++++++
 3 files changed

// File: rtl/baud_pkg.sv
// Shared widths, reset divisor and clamp constants
// for the fractional baud tick generator.
package baud_pkg;

  localparam int DEF_DIV_W        = 16;
  localparam int DEF_FRAC_W       = 4;
  localparam int DEF_OVERSAMPLE   = 16;
  localparam int DEF_RST_DIV_INT  = 325;
  localparam int DEF_RST_DIV_FRAC = 8;

  // Smallest usable os_tick period; 0 and 1 alias to this.
  localparam int MIN_DIV = 2;

endpackage

// File: rtl/frac_divider.sv
// Fractional period counter: D or D+1 clocks per os_tick,
// with the extra clock chosen by accumulator carry-out.
module frac_divider
  import baud_pkg::*;
#(
  parameter int DIV_W  = DEF_DIV_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              en,
  input  logic              sync_clear,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              os_tick
);

  logic [DIV_W-1:0]  cnt;
  logic [DIV_W-1:0]  d_eff;
  logic [DIV_W-1:0]  last;
  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   acc_sum;
  logic              at_last;

  always_comb begin
    acc_sum = {1'b0, acc} + {1'b0, div_frac};
    if (div_int < DIV_W'(MIN_DIV)) begin
      d_eff = DIV_W'(MIN_DIV);
    end else begin
      d_eff = div_int;
    end
    if (acc_sum[FRAC_W]) begin
      last = d_eff;
    end else begin
      last = d_eff - DIV_W'(1);
    end
    // >= so a shorter divisor swapped in mid-count wraps at once
    at_last = (cnt >= last);
  end

  assign os_tick = en & ~sync_clear & at_last;

  always_ff @(posedge clock) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
    end else if (sync_clear) begin
      cnt <= '0;
      acc <= '0;
    end else if (en) begin
      if (at_last) begin
        cnt <= '0;
        acc <= acc_sum[FRAC_W-1:0];
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/baud_tick_gen.sv
// Baud tick generator: oversample/baud strobes, baud_clk
// and a shadowed divisor swapped in on baud boundaries.
module baud_tick_gen
  import baud_pkg::*;
#(
  parameter int DIV_W        = DEF_DIV_W,
  parameter int FRAC_W       = DEF_FRAC_W,
  parameter int OVERSAMPLE   = DEF_OVERSAMPLE,
  parameter int RST_DIV_INT  = DEF_RST_DIV_INT,
  parameter int RST_DIV_FRAC = DEF_RST_DIV_FRAC
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              en,
  input  logic              sync_clear,
  input  logic              cfg_valid,
  input  logic [DIV_W-1:0]  cfg_div_int,
  input  logic [FRAC_W-1:0] cfg_div_frac,
  output logic              cfg_ready,
  output logic              os_tick,
  output logic              baud_tick,
  output logic              baud_clk
);

  localparam int OSW =
    (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [OSW-1:0] OS_LAST =
    OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] OS_MID =
    OSW'(OVERSAMPLE / 2 - 1);

  logic [DIV_W-1:0]  div_int_q;
  logic [FRAC_W-1:0] div_frac_q;
  logic [DIV_W-1:0]  shadow_int;
  logic [FRAC_W-1:0] shadow_frac;
  logic              pending;
  logic [OSW-1:0]    os_cnt;
  logic              baud_clk_q;
  logic              os_wrap;
  logic              os_half;
  logic              accept;
  logic              apply;

  frac_divider #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_frac_divider (
    .clock      (clock),
    .rst        (rst),
    .en         (en),
    .sync_clear (sync_clear),
    .div_int    (div_int_q),
    .div_frac   (div_frac_q),
    .os_tick    (os_tick)
  );

  assign os_wrap   = (os_cnt == OS_LAST);
  assign os_half   = (os_cnt == OS_MID);
  assign baud_tick = os_tick & os_wrap;
  assign baud_clk  = baud_clk_q;
  assign cfg_ready = ~pending;

  // Swap on a baud edge, or at once when the phase is idle or reset
  assign accept = cfg_valid & ~pending;
  assign apply  = pending & (baud_tick | ~en | sync_clear);

  always_ff @(posedge clock) begin
    if (rst) begin
      div_int_q   <= DIV_W'(RST_DIV_INT);
      div_frac_q  <= FRAC_W'(RST_DIV_FRAC);
      shadow_int  <= '0;
      shadow_frac <= '0;
      pending     <= 1'b0;
    end else if (apply) begin
      div_int_q  <= shadow_int;
      div_frac_q <= shadow_frac;
      pending    <= 1'b0;
    end else if (accept) begin
      shadow_int  <= cfg_div_int;
      shadow_frac <= cfg_div_frac;
      pending     <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      os_cnt     <= '0;
      baud_clk_q <= 1'b0;
    end else if (sync_clear) begin
      os_cnt     <= '0;
      baud_clk_q <= 1'b0;
    end else if (os_tick) begin
      if (os_wrap) begin
        os_cnt <= '0;
      end else begin
        os_cnt <= os_cnt + OSW'(1);
      end
      if (os_wrap | os_half) begin
        baud_clk_q <= ~baud_clk_q;
      end
    end
  end

endmodule
